// File: rtl/priority_req_capture.sv
// Request capture and grant stage feeding the 16-to-4 priority encoder.
// Raw requests become sticky pending bits; the encoder's winner is granted on valid/ready.
//
// state | meaning
// IDLE  | no grant outstanding; latch encoder result when it reports active
// GRANT | out_code held stable until the consumer accepts it
module priority_req_capture #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req_in,
    input  logic [15:0] mask,
    input  logic        clear_all,
    output logic [15:0] pend_out,
    input  logic [3:0]  enc_code,
    input  logic        enc_active,
    output logic        out_valid,
    output logic [3:0]  out_code,
    input  logic        out_ready,
    output logic [15:0] pending,
    output logic        lost
);
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic        r_state;
    logic [15:0] r_req_d;
    logic [15:0] r_pending;
    logic        r_lost;
    logic [3:0]  r_out_code;

    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic        w_accept;

    assign w_set    = EDGE_MODE ? (req_in & ~r_req_d) : req_in;
    assign w_accept = (r_state == ST_GRANT) && out_ready;
    assign w_clr    = w_accept ? (16'd1 << r_out_code) : 16'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_req_d    <= 16'hFFFF;
            r_pending  <= 16'd0;
            r_lost     <= 1'b0;
            r_out_code <= 4'd0;
        end else begin
            r_req_d <= req_in;
            if (clear_all) begin
                r_state   <= ST_IDLE;
                r_pending <= 16'd0;
                r_lost    <= 1'b0;
            end else begin
                // set is OR'd in after the clear so a same-cycle re-request survives
                r_pending <= (r_pending & ~w_clr) | w_set;
                if (|(w_set & r_pending & ~w_clr)) begin
                    r_lost <= 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (enc_active) begin
                            r_out_code <= enc_code;
                            r_state    <= ST_GRANT;
                        end
                    end
                    ST_GRANT: begin
                        if (out_ready) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pend_out  = r_pending & mask;
    assign pending   = r_pending;
    assign lost      = r_lost;
    assign out_valid = (r_state == ST_GRANT);
    assign out_code  = r_out_code;

endmodule

// File: tb/tb_priority_req_capture.sv
// Bench for priority_req_capture: an edge-mode and a level-mode instance, each with a
// behavioural encoder, a cycle model checked every negedge, and directed literal checks.
module tb_priority_req_capture;
    logic        clk;
    logic        reset_n;
    logic [15:0] req      [2];
    logic [15:0] msk      [2];
    logic        clr_all  [2];
    logic        rdy      [2];
    logic [15:0] pend_out [2];
    logic [15:0] pend     [2];
    logic        valid    [2];
    logic [3:0]  code     [2];
    logic        lost_o   [2];
    logic [3:0]  enc_code [2];
    logic        enc_act  [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    logic [15:0] m_pend  [2];
    logic [15:0] m_prev  [2];
    logic        m_lost  [2];
    logic        m_valid [2];
    logic [3:0]  m_code  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    priority_req_capture #(.EDGE_MODE(1'b1)) dut_e (
        .clk(clk), .reset_n(reset_n), .req_in(req[0]), .mask(msk[0]),
        .clear_all(clr_all[0]), .pend_out(pend_out[0]), .enc_code(enc_code[0]),
        .enc_active(enc_act[0]), .out_valid(valid[0]), .out_code(code[0]),
        .out_ready(rdy[0]), .pending(pend[0]), .lost(lost_o[0]));

    priority_req_capture #(.EDGE_MODE(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .req_in(req[1]), .mask(msk[1]),
        .clear_all(clr_all[1]), .pend_out(pend_out[1]), .enc_code(enc_code[1]),
        .enc_active(enc_act[1]), .out_valid(valid[1]), .out_code(code[1]),
        .out_ready(rdy[1]), .pending(pend[1]), .lost(lost_o[1]));

    function automatic logic [3:0] highest(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // The downstream encoder, played by the bench.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            enc_act[d]  = |pend_out[d];
            enc_code[d] = highest(pend_out[d]);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: events, served bit, grant of the highest visible pending bit.
    always @(posedge clk) begin
        logic [15:0] ev, served, vis;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_pend[d] = 16'd0; m_lost[d] = 1'b0; m_valid[d] = 1'b0;
                m_code[d] = 4'd0;  m_prev[d] = 16'hFFFF;
            end else begin
                ev     = (d == 0) ? (req[d] & ~m_prev[d]) : req[d];
                served = 16'd0;
                if (m_valid[d] && rdy[d]) served[m_code[d]] = 1'b1;
                vis = m_pend[d] & msk[d];
                if (clr_all[d]) begin
                    m_pend[d] = 16'd0; m_lost[d] = 1'b0; m_valid[d] = 1'b0;
                end else begin
                    for (int i = 0; i < 16; i++)
                        if (ev[i] && m_pend[d][i] && !served[i]) m_lost[d] = 1'b1;
                    m_pend[d] = (m_pend[d] & ~served) | ev;
                    if (m_valid[d]) begin
                        if (rdy[d]) m_valid[d] = 1'b0;
                    end else if (vis != 16'd0) begin
                        m_valid[d] = 1'b1;
                        m_code[d]  = highest(vis);
                    end
                end
                m_prev[d] = req[d];
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_pend_out[%0d]", d), pend_out[d], m_pend[d] & msk[d]);
                chk($sformatf("model_pending[%0d]", d), pend[d], m_pend[d]);
                chk($sformatf("model_valid[%0d]", d), 16'(valid[d]), 16'(m_valid[d]));
                chk($sformatf("model_lost[%0d]", d), 16'(lost_o[d]), 16'(m_lost[d]));
                if (m_valid[d]) chk($sformatf("model_code[%0d]", d), 16'(code[d]), 16'(m_code[d]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 16'd0; msk[d] = 16'hFFFF; clr_all[d] = 1'b0; rdy[d] = 1'b0;
        end
        req[0] = 16'h8001;
        step(); step();
        started = 1;
        chk("reset_valid", 16'(valid[0]), 16'd0);
        chk("reset_code", 16'(code[0]), 16'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_at_release_pending", pend[0], 16'd0);
            chk("held_at_release_valid", 16'(valid[0]), 16'd0);
        end

        // single pulse on bit 5
        req[0] = 16'd0; rdy[0] = 1'b1;
        step();
        req[0] = 16'h0020;
        step();
        chk("pulse5_pending_k", pend[0], 16'h0020);
        chk("pulse5_valid_k", 16'(valid[0]), 16'd0);
        req[0] = 16'd0;
        step();
        chk("pulse5_valid_k1", 16'(valid[0]), 16'd1);
        chk("pulse5_code_k1", 16'(code[0]), 16'd5);
        step();
        chk("pulse5_pending_k2", pend[0], 16'd0);
        chk("pulse5_valid_k2", 16'(valid[0]), 16'd0);

        // bits 3, 9, 14 together
        req[0] = 16'h4208;
        step();
        req[0] = 16'd0;
        step(); chk("multi_code14", 16'(code[0]), 16'd14);
        step(); chk("multi_gap1", 16'(valid[0]), 16'd0);
        step(); chk("multi_code9", 16'(code[0]), 16'd9);
        step();
        step(); chk("multi_code3", 16'(code[0]), 16'd3);
        step();
        chk("multi_idle_valid", 16'(valid[0]), 16'd0);
        chk("multi_idle_pending", pend[0], 16'd0);

        // grant held against mask change and higher request
        rdy[0] = 1'b0; req[0] = 16'h0010;
        step();
        req[0] = 16'd0;
        step(); chk("hold_code4", 16'(code[0]), 16'd4);
        req[0] = 16'h1000; msk[0] = 16'hFFEF;
        step();
        req[0] = 16'd0;
        step(); step();
        chk("hold_code4_still", 16'(code[0]), 16'd4);
        chk("hold_valid_still", 16'(valid[0]), 16'd1);
        chk("hold_pending", pend[0], 16'h1010);
        rdy[0] = 1'b1;
        step();
        chk("hold_accept_pending", pend[0], 16'h1000);
        step(); chk("hold_next_code12", 16'(code[0]), 16'd12);
        step();
        msk[0] = 16'hFFFF;

        // lost flag, same-cycle set/clear, flush in GRANT
        rdy[0] = 1'b0; req[0] = 16'h0080;
        step();
        req[0] = 16'd0;
        step();
        req[0] = 16'h0080;
        step(); chk("lost_set", 16'(lost_o[0]), 16'd1);
        req[0] = 16'd0;
        step();
        rdy[0] = 1'b1; req[0] = 16'h0080;
        step();
        chk("setwins_pending", pend[0], 16'h0080);
        chk("setwins_valid", 16'(valid[0]), 16'd0);
        req[0] = 16'd0; rdy[0] = 1'b0;
        step(); chk("regrant_code7", 16'(code[0]), 16'd7);
        clr_all[0] = 1'b1;
        step();
        clr_all[0] = 1'b0;
        chk("flush_valid", 16'(valid[0]), 16'd0);
        chk("flush_pending", pend[0], 16'd0);
        chk("flush_lost", 16'(lost_o[0]), 16'd0);

        // all sixteen pending
        rdy[0] = 1'b1; req[0] = 16'hFFFF;
        step();
        req[0] = 16'd0;
        for (int i = 15; i >= 0; i--) begin
            step(); chk($sformatf("all16_code%0d", i), 16'(code[0]), 16'(i));
            step(); chk("all16_gap", 16'(valid[0]), 16'd0);
        end
        chk("all16_empty", pend[0], 16'd0);

        // fully masked
        msk[0] = 16'd0; req[0] = 16'h0003;
        step();
        req[0] = 16'd0;
        for (int i = 0; i < 4; i++) step();
        chk("masked_valid", 16'(valid[0]), 16'd0);
        chk("masked_pending", pend[0], 16'h0003);
        chk("masked_pend_out", pend_out[0], 16'd0);
        msk[0] = 16'hFFFF;
        step(); chk("unmask_code1", 16'(code[0]), 16'd1);
        step(); step(); chk("unmask_code0", 16'(code[0]), 16'd0);
        step();

        // level mode: held request
        req[1] = 16'h0004; rdy[1] = 1'b1;
        step(); chk("lvl_pending", pend[1], 16'h0004);
        step();
        chk("lvl_code2", 16'(code[1]), 16'd2);
        chk("lvl_lost", 16'(lost_o[1]), 16'd1);
        step();
        chk("lvl_gap_valid", 16'(valid[1]), 16'd0);
        chk("lvl_gap_pending", pend[1], 16'h0004);
        step(); chk("lvl_regrant", 16'(valid[1]), 16'd1);
        rdy[1] = 1'b0; clr_all[1] = 1'b1;
        step();
        chk("lvl_flush_valid", 16'(valid[1]), 16'd0);
        chk("lvl_flush_pending", pend[1], 16'd0);
        clr_all[1] = 1'b0; req[1] = 16'd0;
        step();

        // reset mid-transfer
        rdy[0] = 1'b0; req[0] = 16'h0100;
        step();
        req[0] = 16'd0;
        step(); chk("pre_reset_code8", 16'(code[0]), 16'd8);
        rdy[0] = 1'b1; reset_n = 1'b0;
        step();
        chk("midreset_valid", 16'(valid[0]), 16'd0);
        chk("midreset_pending", pend[0], 16'd0);
        chk("midreset_code", 16'(code[0]), 16'd0);
        reset_n = 1'b1;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
